// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request at a time, aligned accesses in one cycle, misaligned split into bytes.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word requests into error responses.
module lsu_mem_ctrl #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [2:0]        req_funct3_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
    state_t state;

    logic f3_ok;
    logic aligned;

    always_comb begin
        f3_ok   = 1'b0;
        aligned = 1'b1;
        case (req_funct3_i)
            3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
            3'd4, 3'd5:       f3_ok = !req_we_i;
            default:          f3_ok = 1'b0;
        endcase
        case (req_funct3_i[1:0])
            2'd1:    aligned = !req_addr_i[0];
            2'd2:    aligned = (req_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

`ifndef LSU_MISALIGN_TRAP_EN
    logic [1:0]        idx_q;
    logic [DWIDTH-1:0] asm_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        f3_q;
    logic [1:0]        next_idx;
    logic [1:0]        last_idx;
    logic [DWIDTH-1:0] asm_next;
    logic [DWIDTH-1:0] load_ext;

    // asm_next folds in the byte arriving this cycle so the last byte needs no extra cycle.
    always_comb begin
        next_idx = idx_q + 2'd1;
        last_idx = (f3_q[1:0] == 2'd2) ? 2'd3 : 2'd1;
        asm_next = asm_q;
        asm_next[{idx_q, 3'b000} +: 8] = mem_data_i[7:0];
        case (f3_q)
            3'd1:    load_ext = {{(DWIDTH-16){asm_next[15]}}, asm_next[15:0]};
            3'd5:    load_ext = {{(DWIDTH-16){1'b0}}, asm_next[15:0]};
            default: load_ext = asm_next;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_ready_o    <= 1'b1;
            resp_valid_o   <= 1'b0;
            resp_rdata_o   <= '0;
            resp_err_o     <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            mem_read_en_o  <= 1'b0;
            mem_write_en_o <= 1'b0;
            mem_funct3_o   <= '0;
`ifndef LSU_MISALIGN_TRAP_EN
            idx_q          <= '0;
            asm_q          <= '0;
            wdata_q        <= '0;
            f3_q           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        if (!f3_ok) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else if (aligned) begin
                            state          <= ACCESS;
                            mem_addr_o     <= req_addr_i;
                            mem_funct3_o   <= req_funct3_i;
                            mem_data_o     <= req_wdata_i;
                            mem_read_en_o  <= !req_we_i;
                            mem_write_en_o <= req_we_i;
                        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
`else
                            state          <= SPLIT;
                            idx_q          <= '0;
                            asm_q          <= '0;
                            wdata_q        <= req_wdata_i;
                            f3_q           <= req_funct3_i;
                            mem_addr_o     <= req_addr_i;
                            mem_funct3_o   <= req_we_i ? 3'b000 : 3'b100;
                            mem_data_o     <= {{(DWIDTH-8){1'b0}}, req_wdata_i[7:0]};
                            mem_read_en_o  <= !req_we_i;
                            mem_write_en_o <= req_we_i;
`endif
                        end
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    mem_read_en_o  <= 1'b0;
                    mem_write_en_o <= 1'b0;
                    resp_valid_o   <= 1'b1;
                    resp_err_o     <= 1'b0;
                    resp_rdata_o   <= mem_read_en_o ? mem_data_i : '0;
                end
`ifndef LSU_MISALIGN_TRAP_EN
                SPLIT: begin
                    asm_q <= asm_next;
                    if (idx_q == last_idx) begin
                        state          <= RESP;
                        mem_read_en_o  <= 1'b0;
                        mem_write_en_o <= 1'b0;
                        resp_valid_o   <= 1'b1;
                        resp_err_o     <= 1'b0;
                        resp_rdata_o   <= mem_read_en_o ? load_ext : '0;
                    end else begin
                        idx_q      <= next_idx;
                        mem_addr_o <= mem_addr_o + AWIDTH'(1);
                        mem_data_o <= {{(DWIDTH-8){1'b0}}, wdata_q[{next_idx, 3'b000} +: 8]};
                    end
                end
`endif
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-array memory, spec-level model producing per-cycle expectations.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trapping variant.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [2:0]  mem_funct3;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_funct3),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_read_en_o(mem_rd_en), .mem_write_en_o(mem_wr_en),
        .mem_funct3_o(mem_funct3), .mem_data_i(mem_rdata)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- memory seen by the DUT ----------------
    logic [7:0] dmem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int mem_ver = 0;

    function automatic logic [7:0] rd_dmem(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(mem_addr or mem_funct3 or mem_ver) begin : mem_read
        logic [31:0] w;
        w = {rd_dmem(mem_addr + 32'd3), rd_dmem(mem_addr + 32'd2),
             rd_dmem(mem_addr + 32'd1), rd_dmem(mem_addr)};
        case (mem_funct3)
            3'd0:    mem_rdata = {{24{w[7]}}, w[7:0]};
            3'd1:    mem_rdata = {{16{w[15]}}, w[15:0]};
            3'd4:    mem_rdata = {24'h0, w[7:0]};
            3'd5:    mem_rdata = {16'h0, w[15:0]};
            default: mem_rdata = w;
        endcase
    end

    always @(posedge clk) begin : mem_write
        int n;
        if (mem_wr_en === 1'b1) begin
            n = (mem_funct3[1:0] == 2'd0) ? 1 : (mem_funct3[1:0] == 2'd1) ? 2 : 4;
            for (int k = 0; k < n; k++) dmem[mem_addr + 32'(k)] = mem_wdata[8*k +: 8];
            mem_ver++;
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        dmem[a] = b;
        ref_mem[a] = b;
        mem_ver++;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic        err;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    function automatic bit f3_valid(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = rd_ref(a + 32'(k));
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    exp_t cur;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("req_ready", {31'h0, req_ready}, {31'h0, cur.req_ready});
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, cur.resp_valid});
            chk("mem_read_en", {31'h0, mem_rd_en}, {31'h0, cur.rd});
            chk("mem_write_en", {31'h0, mem_wr_en}, {31'h0, cur.wr});
            if (cur.resp_valid) begin
                chk("resp_rdata", resp_rdata, cur.rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, cur.err});
            end
            if (cur.rd || cur.wr) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_funct3", {29'h0, mem_funct3}, {29'h0, cur.f3});
            end
            if (cur.wr) chk("mem_data", mem_wdata, cur.data);
        end
    end

    // ---------------- driver tasks (called on a negedge, DUT idle) ----------------
    task automatic idle(input int n);
        exp_t r;
        for (int i = 0; i < n; i++) begin
            r = '0;
            r.req_ready = 1'b1;
            exp_q.push_back(r);
        end
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int d,
                          output logic [31:0] got_rdata, output logic got_err);
        exp_t r;
        int n, nacc;
        bit ok, al, err;
        logic [31:0] rd_exp;
        ok  = f3_valid(we, f3);
        n   = size_of(f3);
        al  = (addr & 32'(n - 1)) == 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = !ok || !al;
`else
        err = !ok;
`endif
        nacc = 0;
        if (!err && al) begin
            r = '0; r.rd = !we; r.wr = we; r.addr = addr; r.f3 = f3; r.data = wdata;
            exp_q.push_back(r);
            nacc = 1;
        end else if (!err) begin
            for (int k = 0; k < n; k++) begin
                r = '0; r.rd = !we; r.wr = we; r.addr = addr + 32'(k);
                r.f3 = we ? 3'b000 : 3'b100;
                r.data = {24'h0, wdata[8*k +: 8]};
                exp_q.push_back(r);
            end
            nacc = n;
        end
        rd_exp = (!err && !we) ? model_load(addr, f3) : 32'h0;
        if (!err && we)
            for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
        for (int i = 0; i <= d; i++) begin
            r = '0; r.resp_valid = 1'b1; r.rdata = rd_exp; r.err = err;
            exp_q.push_back(r);
        end
        r = '0; r.req_ready = 1'b1;
        exp_q.push_back(r);

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        got_rdata = 32'hx; got_err = 1'bx;
        for (int i = 0; i < nacc + d + 2; i++) begin
            @(negedge clk);
            // Garbage requests while busy must be ignored.
            req_valid  = (i <= nacc + d) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom_range(0, 7));
            resp_ready = (i == nacc + d);
            if (i == nacc) begin
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end
        resp_ready = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_data"}, mem_wdata, 32'h0);
        chk({tag, "_mem_rd"}, {31'h0, mem_rd_en}, 32'h0);
        chk({tag, "_mem_wr"}, {31'h0, mem_wr_en}, 32'h0);
        chk({tag, "_mem_funct3"}, {29'h0, mem_funct3}, 32'h0);
    endtask

`ifndef LSU_MISALIGN_TRAP_EN
    task automatic split_store_reset();
        exp_t r;
        logic [31:0] a;
        logic [31:0] w;
        a = 32'h01000041;
        w = 32'h11223344;
        for (int k = 0; k < 4; k++) poke(a + 32'(k), 8'h55);
        for (int k = 0; k < 3; k++) begin
            r = '0; r.wr = 1'b1; r.addr = a + 32'(k); r.f3 = 3'b000; r.data = {24'h0, w[8*k +: 8]};
            exp_q.push_back(r);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = w; req_funct3 = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_reset("tp6_rst");
        ref_mem[a]          = w[7:0];
        ref_mem[a + 32'd1]  = w[15:8];
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("tp6_b0", {24'h0, rd_dmem(a)}, 32'h44);
        chk("tp6_b1", {24'h0, rd_dmem(a + 32'd1)}, 32'h33);
        chk("tp6_b2", {24'h0, rd_dmem(a + 32'd2)}, 32'h55);
        chk("tp6_b3", {24'h0, rd_dmem(a + 32'd3)}, 32'h55);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        resp_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 64; i++) poke(32'h01000000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 8; i++) poke(32'hFFFFFFFC + 32'(i), 8'($urandom));

        // Test plan 1: aligned LW
        poke(32'h01000010, 8'hD4); poke(32'h01000011, 8'hC3);
        poke(32'h01000012, 8'hB2); poke(32'h01000013, 8'hA1);
        do_req(1'b0, 32'h01000010, 32'h0, 3'd2, 0, got, gerr);
        chk("tp1_lw", got, 32'hA1B2C3D4);

        // Test plan 4: invalid funct3 load
        do_req(1'b0, 32'h01000010, 32'h0, 3'd3, 1, got, gerr);
        chk("tp4_err", {31'h0, gerr}, 32'h1);
        chk("tp4_rdata", got, 32'h0);

        // Test plan 5: response held three cycles
        do_req(1'b0, 32'h01000010, 32'h0, 3'd4, 3, got, gerr);
        chk("tp5_lbu", got, 32'h000000D4);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 32'h01000002, 32'h0, 3'd2, 0, got, gerr);
        chk("tp4_trap_err", {31'h0, gerr}, 32'h1);
        chk("tp4_trap_rdata", got, 32'h0);
`else
        // Test plan 2: misaligned LH / LHU
        poke(32'h01000003, 8'h80); poke(32'h01000004, 8'hFF);
        do_req(1'b0, 32'h01000003, 32'h0, 3'd1, 0, got, gerr);
        chk("tp2_lh", got, 32'hFFFFFF80);
        do_req(1'b0, 32'h01000003, 32'h0, 3'd5, 2, got, gerr);
        chk("tp2_lhu", got, 32'h0000FF80);

        // Test plan 3: misaligned SW then aligned LW
        poke(32'h01000000, 8'h11);
        do_req(1'b1, 32'h01000001, 32'hDEADBEEF, 3'd2, 0, got, gerr);
        chk("tp3_sw_rdata", got, 32'h0);
        chk("tp3_sw_err", {31'h0, gerr}, 32'h0);
        do_req(1'b0, 32'h01000000, 32'h0, 3'd2, 0, got, gerr);
        chk("tp3_lw", got, 32'hADBEEF11);
        chk("tp3_b4", {24'h0, rd_dmem(32'h01000004)}, 32'hDE);

        // Address wrap on a split word load
        poke(32'hFFFFFFFE, 8'h01); poke(32'hFFFFFFFF, 8'h02);
        poke(32'h00000000, 8'h03); poke(32'h00000001, 8'h84);
        do_req(1'b0, 32'hFFFFFFFE, 32'h0, 3'd2, 1, got, gerr);
        chk("wrap_lw", got, 32'h84030201);

        // Test plan 6: reset in the middle of a split store
        split_store_reset();
`endif

        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else addr = 32'h01000000 + 32'($urandom_range(0, 31));
            do_req(we, addr, $urandom, f3, $urandom_range(0, 3), got, gerr);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
